// File: rtl/mips_data_mem_if.sv
// Request/response bus between the MIPS memory-control stage and mips_data_mem.
// The master drives a load/store request; the slave answers with a one-cycle response.
interface mips_data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req_valid, mem_read, mem_write, size, unsigned_ld, addr, wdata,
        input  req_ready, rsp_valid, rdata, err
    );

    modport slave (
        input  req_valid, mem_read, mem_write, size, unsigned_ld, addr, wdata,
        output req_ready, rsp_valid, rdata, err
    );
endinterface

// File: rtl/mips_data_mem.sv
// Big-endian MIPS data memory with a valid/ready request, programmable wait latency
// and a single-cycle response. Optional alignment checking: MIPS_DMEM_ALIGN_CHECK_EN.
module mips_data_mem #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic             clk,
    input  logic             reset,
    mips_data_mem_if.slave   bus
);

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic                    rd_r;
    logic                    wr_r;
    logic [1:0]              size_r;
    logic                    uns_r;
    logic [DEPTH_LOG2+1:0]   addr_r;
    logic [31:0]             wdata_r;
    logic                    rsp_valid_r;
    logic [31:0]             rdata_r;
    logic                    err_r;

    logic [31:0]             mem_r [0:DEPTH-1];

    logic [DEPTH_LOG2-1:0]   word_idx_s;
    logic [1:0]              eff_off_s;
    logic                    misalign_s;
    logic                    fault_s;
    logic [31:0]             word_s;
    logic [31:0]             load_s;
    logic [31:0]             store_word_s;
    logic                    unused_addr_s;

    // Replace the addressed lane of a stored word, leaving the other lanes intact.
    function automatic logic [31:0] merge_store(
        input logic [31:0] old_word,
        input logic [31:0] wd,
        input logic [1:0]  sz,
        input logic [1:0]  off
    );
        logic [31:0] res;
        res = old_word;
        case (sz)
            2'b00: res = wd;
            2'b01: begin
                if (off[1]) res[15:0]  = wd[15:0];
                else        res[31:16] = wd[15:0];
            end
            2'b10: begin
                case (off)
                    2'b00:   res[31:24] = wd[7:0];
                    2'b01:   res[23:16] = wd[7:0];
                    2'b10:   res[15:8]  = wd[7:0];
                    default: res[7:0]   = wd[7:0];
                endcase
            end
            default: res = old_word;
        endcase
        return res;
    endfunction

    // Pick the addressed lane, right-justify it and sign- or zero-extend it.
    function automatic logic [31:0] load_lane(
        input logic [31:0] word,
        input logic [1:0]  sz,
        input logic [1:0]  off,
        input logic        uns
    );
        logic [15:0] half;
        logic [7:0]  byt;
        logic [31:0] res;
        half = off[1] ? word[15:0] : word[31:16];
        case (off)
            2'b00:   byt = word[31:24];
            2'b01:   byt = word[23:16];
            2'b10:   byt = word[15:8];
            default: byt = word[7:0];
        endcase
        case (sz)
            2'b00:   res = word;
            2'b01:   res = uns ? {16'h0000, half} : {{16{half[15]}}, half};
            2'b10:   res = uns ? {24'h000000, byt} : {{24{byt[7]}}, byt};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    assign word_idx_s    = addr_r[DEPTH_LOG2+1:2];
    assign unused_addr_s = &{1'b0, bus.addr[31:DEPTH_LOG2+2]};

    // Resolve the effective byte offset and, when enabled, flag misaligned accesses.
    always_comb begin
        eff_off_s  = addr_r[1:0];
        misalign_s = 1'b0;
`ifdef MIPS_DMEM_ALIGN_CHECK_EN
        case (size_r)
            2'b00:   misalign_s = (addr_r[1:0] != 2'b00);
            2'b01:   misalign_s = addr_r[0];
            default: misalign_s = 1'b0;
        endcase
`else
        case (size_r)
            2'b00:   eff_off_s = 2'b00;
            2'b01:   eff_off_s = {addr_r[1], 1'b0};
            default: eff_off_s = addr_r[1:0];
        endcase
`endif
    end

    // Decode the held request against the current array word.
    always_comb begin
        fault_s      = (rd_r == wr_r) || (size_r == 2'b11) || misalign_s;
        word_s       = mem_r[word_idx_s];
        load_s       = load_lane(word_s, size_r, eff_off_s, uns_r);
        store_word_s = merge_store(word_s, wdata_r, size_r, eff_off_s);
    end

    // Array write port: the read-modify-write commits on the edge that leaves RESP.
    always_ff @(posedge clk) begin
        if ((state_r == RESP) && wr_r && !fault_s) begin
            mem_r[word_idx_s] <= store_word_s;
        end
    end

    // Request/response sequencer with registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            rd_r        <= 1'b0;
            wr_r        <= 1'b0;
            size_r      <= 2'b00;
            uns_r       <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= 32'h0000_0000;
            rsp_valid_r <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            err_r       <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        rd_r    <= bus.mem_read;
                        wr_r    <= bus.mem_write;
                        size_r  <= bus.size;
                        uns_r   <= bus.unsigned_ld;
                        addr_r  <= bus.addr[DEPTH_LOG2+1:0];
                        wdata_r <= bus.wdata;
                        if (LATENCY == 0) begin
                            state_r <= RESP;
                        end else begin
                            cnt_r   <= LAT_M1;
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    rsp_valid_r <= 1'b1;
                    err_r       <= fault_s;
                    rdata_r     <= (fault_s || !rd_r) ? 32'h0000_0000 : load_s;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Ready depends only on state so there is no path from req_valid.
    assign bus.req_ready = (state_r == IDLE);
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rdata     = rdata_r;
    assign bus.err       = err_r;

endmodule

// File: doc/mips_data_mem.md
# mips_data_mem

Data-memory responder for the single-cycle/multicycle MIPS datapath: it is the far end of the memory-control signals produced by the main control decoder (MemRead, MemWrite, Sb, Sh, Lbu, Lhu). It accepts one load/store request at a time over a valid/ready handshake and holds it for a programmable wait latency. It then performs a big-endian word/half/byte access on an internal word array and returns a single-cycle response carrying load data or a store acknowledge.

## Interface
- DEPTH_LOG2, 8: log2 of the number of 32-bit words in the array (256 words).
- LATENCY, 2: wait cycles between request acceptance and the access; legal range 0–15.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- mem_read  input  1  load request (MemRead/Lbu/Lhu class).
- mem_write  input  1  store request (MemWrite/Sb/Sh class).
- size  input  2  00 word, 01 halfword, 10 byte, 11 illegal.
- unsigned_ld  input  1  zero-extend halfword/byte loads; ignored for word and for stores.
- addr  input  32  byte address.
- wdata  input  32  store data; the half/byte value is in its low bits.
- rsp_valid  output  1  one-cycle response pulse.
- rdata  output  32  load result; 0 for stores and errors.
- err  output  1  request rejected; valid with rsp_valid.

## Operation
- States are IDLE, WAIT and RESP.
- Reset values: state is IDLE, req_ready is 1, rsp_valid is 0, rdata is 0, err is 0, and the wait counter is 0. Array contents are not affected by reset.
- IDLE: req_ready is 1. When req_valid is high, the request fields are latched into holding registers.
  - If LATENCY is 0, the next state is RESP.
  - Otherwise the counter is loaded with LATENCY-1 and the next state is WAIT.
- WAIT: req_ready is 0 and the counter decrements. When the counter reaches 0, the next state is RESP.
- RESP: the access executes on this edge. rsp_valid is 1 for exactly this cycle, then the state returns to IDLE.
- req_ready is 0 during RESP. Back-to-back requests therefore have at least one idle cycle between responses.
- Word index is addr[DEPTH_LOG2+1:2]. Higher address bits are ignored, so addresses wrap modulo 4·2^DEPTH_LOG2 bytes.
- Byte lanes are big-endian:
  - addr[1:0]=0 selects bits 31:24.
  - addr[1]=0 selects halfword bits 31:16.
- Stores:
  - Word stores write all four lanes.
  - Halfword stores write wdata[15:0] into the selected halfword lane.
  - Byte stores write wdata[7:0] into the selected byte lane.
  - Lanes that are not written keep their contents (read-modify-write in the same cycle).
- Loads:
  - The selected lane is right-justified in rdata.
  - Halfword and byte loads are sign-extended unless unsigned_ld is 1, in which case they are zero-extended.
- Errors: err=1 and rdata=0 when any of these holds, and the array is not modified:
  - mem_read and mem_write are both 1;
  - both are 0;
  - size is 11.
- A request is sampled only while the state is IDLE. Input changes during WAIT or RESP have no effect.
- Reset asserted mid-operation returns the block to IDLE immediately. A pending store is discarded, and the array is unchanged for that request.

## Timing
- Request accepted at edge N, meaning req_valid and req_ready are both high before edge N.
- rsp_valid, rdata and err are registered and are high/valid in the cycle after edge N+LATENCY+1.
- A store becomes visible in the array at edge N+LATENCY+1. A load accepted later returns the new data.
- The next request can be accepted at the earliest at edge N+LATENCY+2.
- req_ready is combinational from state only. It has no path from req_valid.

## Configuration
- MIPS_DMEM_ALIGN_CHECK_EN defined:
  - A halfword access with addr[0]=1 is flagged as an error.
  - A word access with addr[1:0]≠0 is flagged as an error.
  - A flagged access sets err=1, rdata=0, and performs no write.
- Not defined: misalignment is not checked.
  - For halfwords, addr[0] is forced to 0.
  - For words, addr[1:0] is forced to 0.
  - err reports only the op/size errors listed under Operation.

## Test plan
- Reset, then a word store of 0xDEADBEEF at addr 0x10. Then a word load from 0x10. Expected: the load gives rdata=0xDEADBEEF, err=0, and rsp_valid appears exactly LATENCY+1 cycles after acceptance.
- Byte store of 0x80 at 0x11, then loads at 0x11.
  - Signed load: 0xFFFFFF80.
  - Unsigned load: 0x00000080.
  - Word load at 0x10: 0xDE80BEEF.
- Halfword store of 0x1234 at 0x12, then a word load at 0x10. Expected: 0xDE801234 (bits 31:16 unchanged).
- Address wrap: a word store at 0x400 with DEPTH_LOG2=8, then a load from 0x000. Expected: the same data.
- Illegal cases each give err=1, rdata=0, and the array unchanged:
  - mem_read=mem_write=1;
  - size=11;
  - with the macro defined, a word load at 0x13.
- Reset asserted in WAIT during a store to 0x20 that was preceded by 0x0 written there. Expected: no rsp_valid, req_ready=1, and a later load at 0x20 returns 0x0.
